// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising 16-lane PRBS31 checker for the 512-bit cable-test stream
// Each beat is predicted from the previous beat, so no seed is needed; tracks lock and counts bit errors.
module prbs_checker #(
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 48
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [511:0]     s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic             locked,
  output logic             error_pulse,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] beat_count,
  output logic [15:0]      lock_loss_count
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W = $clog2(LOSS_COUNT + 1);
  localparam int SUM_W = ((CNT_W > 10) ? CNT_W : 10) + 1;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [511:0]       ref_q, ref_d;
  logic               ref_valid_q, ref_valid_d;
  logic [511:0]       xor_q, xor_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [BAD_W-1:0]   bad_q, bad_d;
  logic [CNT_W-1:0]   error_count_q, error_count_d;
  logic [CNT_W-1:0]   beat_count_q, beat_count_d;
  logic [15:0]        lock_loss_q, lock_loss_d;
  logic               error_pulse_q, error_pulse_d;

  logic               accept;
  logic [511:0]       pred;
  logic [9:0]         popcount;
  logic               beat_err;
  logic               lose;
  logic               gain;
  logic [SUM_W-1:0]   err_sum;

  // Next 32 serial bits of b[n] = b[n-31] ^ b[n-28]; the top bits reuse freshly predicted ones.
  function automatic logic [31:0] predict(input logic [31:0] c);
    logic [31:0] p;
    p = '0;
    for (int j = 0; j < 28; j++) p[j] = c[j+1] ^ c[j+4];
    for (int j = 28; j < 31; j++) p[j] = c[j+1] ^ p[j-28];
    p[31] = p[0] ^ p[3];
    return p;
  endfunction

  assign s_axis_tready = ~reset;
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    pred = '0;
    for (int i = 0; i < 16; i++) pred[32*i +: 32] = predict(ref_q[32*i +: 32]);
  end

  always_comb begin
    popcount = '0;
    for (int i = 0; i < 512; i++) popcount = popcount + 10'(xor_q[i]);
  end

  assign beat_err = (popcount != 10'd0);

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_HUNT;
    else       state_q <= state_d;
  end

  // FSM: next state, decided by the popcount of the beat compared last cycle
  always_comb begin
    state_d = state_q;
    if (cmp_valid_q) begin
      case (state_q)
        ST_HUNT:   if (!beat_err && run_q == RUN_W'(LOCK_COUNT - 1)) state_d = ST_LOCKED;
        ST_LOCKED: if (beat_err && bad_q == BAD_W'(LOSS_COUNT - 1))  state_d = ST_HUNT;
        default:   state_d = ST_HUNT;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    locked = (state_q == ST_LOCKED);
    lose   = (state_q == ST_LOCKED) && (state_d == ST_HUNT);
    gain   = (state_q == ST_HUNT) && (state_d == ST_LOCKED);
  end

  // A beat accepted on the lock-loss edge is discarded from comparison but still becomes the reference.
  always_comb begin
    ref_d       = accept ? s_axis_tdata : ref_q;
    ref_valid_d = accept ? 1'b1 : (lose ? 1'b0 : ref_valid_q);
    xor_d       = accept ? (s_axis_tdata ^ pred) : xor_q;
    cmp_valid_d = accept & ref_valid_q & ~lose;
  end

  always_comb begin
    run_d = run_q;
    bad_d = bad_q;
    if (cmp_valid_q) begin
      if (state_q == ST_HUNT) begin
        run_d = (beat_err || gain) ? '0 : run_q + RUN_W'(1);
        bad_d = '0;
      end else begin
        bad_d = (!beat_err || lose) ? '0 : bad_q + BAD_W'(1);
        run_d = '0;
      end
    end
  end

  always_comb begin
    err_sum       = SUM_W'(error_count_q) + SUM_W'(popcount);
    error_count_d = error_count_q;
    beat_count_d  = beat_count_q;
    lock_loss_d   = lock_loss_q;
    error_pulse_d = 1'b0;
    if (cmp_valid_q && state_q == ST_LOCKED) begin
      error_pulse_d = beat_err;
      beat_count_d  = (&beat_count_q) ? beat_count_q : beat_count_q + CNT_W'(1);
      error_count_d = (err_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    end
    if (lose) lock_loss_d = (&lock_loss_q) ? lock_loss_q : lock_loss_q + 16'd1;
    if (clear) begin
      error_count_d = '0;
      beat_count_d  = '0;
      lock_loss_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_q         <= '0;
      ref_valid_q   <= 1'b0;
      xor_q         <= '0;
      cmp_valid_q   <= 1'b0;
      run_q         <= '0;
      bad_q         <= '0;
      error_count_q <= '0;
      beat_count_q  <= '0;
      lock_loss_q   <= '0;
      error_pulse_q <= 1'b0;
    end else begin
      ref_q         <= ref_d;
      ref_valid_q   <= ref_valid_d;
      xor_q         <= xor_d;
      cmp_valid_q   <= cmp_valid_d;
      run_q         <= run_d;
      bad_q         <= bad_d;
      error_count_q <= error_count_d;
      beat_count_q  <= beat_count_d;
      lock_loss_q   <= lock_loss_d;
      error_pulse_q <= error_pulse_d;
    end
  end

  assign error_pulse     = error_pulse_q;
  assign error_count     = error_count_q;
  assign beat_count      = beat_count_q;
  assign lock_loss_count = lock_loss_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed bench for prbs_checker
// Drives a serial-model PRBS31 stream; a second instance with 4-bit counters exercises saturation.
module tb_prbs_checker;

  logic         clock;
  logic         reset;
  logic         clear;
  logic [511:0] s_axis_tdata;
  logic         s_axis_tvalid;

  logic         s_axis_tready;
  logic         locked;
  logic         error_pulse;
  logic [47:0]  error_count;
  logic [47:0]  beat_count;
  logic [15:0]  lock_loss_count;

  logic         sat_tready;
  logic         sat_locked;
  logic         sat_error_pulse;
  logic [3:0]   sat_error_count;
  logic [3:0]   sat_beat_count;
  logic [15:0]  sat_lock_loss_count;

  int checks;
  int failures;
  int pulse_cnt;

  logic [30:0]  lfsr [16];
  logic [511:0] d;
  logic [511:0] flip7;
  logic [511:0] flip_l3b5;
  int           p0;

  prbs_checker #(.LOCK_COUNT(8), .LOSS_COUNT(4), .CNT_W(48)) u_dut (
    .clock           (clock),
    .reset           (reset),
    .clear           (clear),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .locked          (locked),
    .error_pulse     (error_pulse),
    .error_count     (error_count),
    .beat_count      (beat_count),
    .lock_loss_count (lock_loss_count)
  );

  prbs_checker #(.LOCK_COUNT(8), .LOSS_COUNT(4), .CNT_W(4)) u_sat (
    .clock           (clock),
    .reset           (reset),
    .clear           (clear),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (sat_tready),
    .locked          (sat_locked),
    .error_pulse     (sat_error_pulse),
    .error_count     (sat_error_count),
    .beat_count      (sat_beat_count),
    .lock_loss_count (sat_lock_loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (error_pulse === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [511:0] data);
    s_axis_tdata  = data;
    s_axis_tvalid = 1'b1;
    cyc();
    s_axis_tvalid = 1'b0;
  endtask

  // Serial reference generator: state holds b[n-31..n-1], oldest in bit 0.
  task automatic gen(output logic [511:0] w);
    logic nb;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 32; j++) begin
        nb = lfsr[i][0] ^ lfsr[i][3];
        w[32*i+j] = nb;
        lfsr[i] = {nb, lfsr[i][30:1]};
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    pulse_cnt     = 0;
    reset         = 1'b1;
    clear         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 16; i++) lfsr[i] = 31'(32'h1357_9BDF * (i + 1)) | 31'h1;
    flip7 = '0;
    for (int k = 0; k < 7; k++) flip7[32*k] = 1'b1;
    flip_l3b5 = '0;
    flip_l3b5[3*32+5] = 1'b1;

    cyc(); cyc(); cyc();
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_err_cnt", 64'(error_count), 64'd0);
    check("rst_beat_cnt", 64'(beat_count), 64'd0);
    check("rst_loss_cnt", 64'(lock_loss_count), 64'd0);
    check("rst_pulse", 64'(error_pulse), 64'd0);

    reset = 1'b0;
    #1;
    check("tready_up", 64'(s_axis_tready), 64'd1);

    // 100 clean beats: beat 1 is reference only, beats 2..9 lock, 10..100 counted
    for (int n = 1; n <= 100; n++) begin
      gen(d);
      beat(d);
      if (n == 9)  check("lock_not_yet", 64'(locked), 64'd0);
      if (n == 10) check("lock_rise", 64'(locked), 64'd1);
    end
    cyc();
    check("clean_beat_cnt", 64'(beat_count), 64'd91);
    check("clean_err_cnt", 64'(error_count), 64'd0);
    check("clean_pulses", 64'(pulse_cnt), 64'd0);

    // single flipped bit: 1 error in that beat, 3 in the next
    p0 = pulse_cnt;
    gen(d); beat(d ^ flip_l3b5);
    gen(d); beat(d);
    gen(d); beat(d);
    cyc(); cyc();
    check("flip_err_cnt", 64'(error_count), 64'd4);
    check("flip_pulses", 64'(pulse_cnt - p0), 64'd2);
    check("flip_locked", 64'(locked), 64'd1);
    check("flip_beat_cnt", 64'(beat_count), 64'd94);

    // four junk beats lose lock; relock after 1 reference plus 8 clean beats
    for (int n = 0; n < 4; n++) beat({512{1'b1}});
    check("junk_still_locked", 64'(locked), 64'd1);
    for (int n = 1; n <= 10; n++) begin
      gen(d);
      beat(d);
      if (n == 1) begin
        check("loss_locked", 64'(locked), 64'd0);
        check("loss_cnt", 64'(lock_loss_count), 64'd1);
      end
      if (n == 9)  check("relock_not_yet", 64'(locked), 64'd0);
      if (n == 10) check("relock", 64'(locked), 64'd1);
    end

    // reset mid-LOCKED: outputs drop without a clock edge
    reset = 1'b1;
    #2;
    check("mid_rst_locked", 64'(locked), 64'd0);
    check("mid_rst_tready", 64'(s_axis_tready), 64'd0);
    check("mid_rst_err_cnt", 64'(error_count), 64'd0);
    check("mid_rst_beat_cnt", 64'(beat_count), 64'd0);
    check("mid_rst_loss_cnt", 64'(lock_loss_count), 64'd0);
    cyc(); cyc();
    reset = 1'b0;

    // tvalid on every other cycle: same result as the continuous stream
    p0 = pulse_cnt;
    for (int n = 1; n <= 100; n++) begin
      gen(d);
      beat(d);
      if (n == 9) check("tog_lock_not_yet", 64'(locked), 64'd0);
      cyc();
      if (n == 9) check("tog_lock_rise", 64'(locked), 64'd1);
    end
    check("tog_beat_cnt", 64'(beat_count), 64'd91);
    check("tog_err_cnt", 64'(error_count), 64'd0);
    check("tog_pulses", 64'(pulse_cnt - p0), 64'd0);

    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clr_err_cnt", 64'(error_count), 64'd0);
    check("clr_beat_cnt", 64'(beat_count), 64'd0);
    check("clr_sat_err_cnt", 64'(sat_error_count), 64'd0);
    check("clr_locked", 64'(locked), 64'd1);

    // bit-0 flips in 7 lanes give 7 errors and do not disturb the next prediction
    for (int k = 0; k < 7; k++) begin
      gen(d);
      if (k % 2 == 0) d = d ^ flip7;
      beat(d);
    end
    cyc();
    check("sat_err_cnt", 64'(sat_error_count), 64'd15);
    check("sat_beat_cnt", 64'(sat_beat_count), 64'd7);
    check("wide_err_cnt", 64'(error_count), 64'd28);
    check("sat_locked", 64'(sat_locked), 64'd1);

    // clear coincides with the counter update of an errored beat
    gen(d); beat(d ^ flip7);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clr_upd_err_cnt", 64'(error_count), 64'd0);
    check("clr_upd_beat_cnt", 64'(beat_count), 64'd0);
    check("clr_upd_sat_err", 64'(sat_error_count), 64'd0);
    gen(d); beat(d);
    gen(d); beat(d ^ flip7);
    cyc();
    check("post_clr_err_cnt", 64'(error_count), 64'd7);
    check("post_clr_sat_err", 64'(sat_error_count), 64'd7);
    check("post_clr_beat_cnt", 64'(beat_count), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
